// File: rtl/uart_transmitir_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer offers tx_data with tx_valid. The transmitter drives tx_ready.
interface uart_transmitir_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_transmitir.sv
// Bit-clocked UART transmitter: one bit per outclk cycle, one-deep holding register,
// optional parity, 1 or 2 stop bits, back-to-back frames with no idle gap.
module uart_transmitir #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic               outclk,
  input  logic               reset,
  uart_transmitir_if.slave   tx,
  output logic               SalidaTx,
  output logic               busy,
  output logic               frame_done
);

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 hold_full_q, hold_full_d;
  logic                 parity_q, parity_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 load;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] v);
    return (^v) ^ (PARITY_ODD != 0);
  endfunction

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    hold_full_d = hold_full_q;
    parity_d    = parity_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    load        = 1'b0;

    // A load needs hold_full=1 and an accept needs hold_full=0, so they never collide.
    if (tx.tx_valid && !hold_full_q) begin
      hold_d      = tx.tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        line_d = 1'b1;
        if (hold_full_q) load = 1'b1;
      end
      START: begin
        state_d = DATA;
        line_d  = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
          cnt_d = '0;
          if (PARITY_EN != 0) begin
            state_d = PARITY;
            line_d  = parity_q;
          end else begin
            state_d = STOP;
            line_d  = 1'b1;
          end
        end else begin
          line_d  = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_d = STOP;
        line_d  = 1'b1;
        cnt_d   = '0;
      end
      STOP: begin
        if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            line_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase

    // Parity is latched from the byte moving into the shifter, so a later accept cannot disturb it.
    if (load) begin
      state_d     = START;
      line_d      = 1'b0;
      shift_d     = hold_q;
      parity_d    = parity_of(hold_q);
      hold_full_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge outclk) begin
    hold_q   <= hold_d;
    shift_q  <= shift_d;
    parity_q <= parity_d;
    if (reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      line_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      line_q      <= line_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tx.tx_ready = !hold_full_q;
  assign SalidaTx    = line_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_uart_transmitir.sv
// Directed bench for uart_transmitir: default, even-parity and odd-parity instances
// share one clock and reset.
module tb_uart_transmitir;

  logic       outclk;
  logic       reset;
  logic [7:0] tx_data;
  logic [2:0] vld;
  logic       line0, line1, line2, bsy0, bsy1, bsy2, fd0, fd1, fd2;
  logic [2:0] line, bsy, fd, rdy;
  int         passed = 0;
  int         total  = 0;

  uart_transmitir_if #(.DATA_BITS(8)) if0 ();
  uart_transmitir_if #(.DATA_BITS(8)) if1 ();
  uart_transmitir_if #(.DATA_BITS(8)) if2 ();

  assign if0.tx_data = tx_data;
  assign if1.tx_data = tx_data;
  assign if2.tx_data = tx_data;
  assign if0.tx_valid = vld[0];
  assign if1.tx_valid = vld[1];
  assign if2.tx_valid = vld[2];
  assign line = {line2, line1, line0};
  assign bsy  = {bsy2, bsy1, bsy0};
  assign fd   = {fd2, fd1, fd0};
  assign rdy  = {if2.tx_ready, if1.tx_ready, if0.tx_ready};

  uart_transmitir dut0 (.outclk(outclk), .reset(reset), .tx(if0.slave),
                        .SalidaTx(line0), .busy(bsy0), .frame_done(fd0));
  uart_transmitir #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
                        .outclk(outclk), .reset(reset), .tx(if1.slave),
                        .SalidaTx(line1), .busy(bsy1), .frame_done(fd1));
  uart_transmitir #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (
                        .outclk(outclk), .reset(reset), .tx(if2.slave),
                        .SalidaTx(line2), .busy(bsy2), .frame_done(fd2));

  initial begin
    outclk = 1'b0;
    forever #5 outclk = ~outclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge outclk);
    @(negedge outclk);
  endtask

  // Frame bit k of exp is the line value in the k-th cycle after the accept edge.
  task automatic run_frame(input int sel, input logic [7:0] d, input logic [11:0] exp,
                           input int len, input string name);
    @(negedge outclk);
    tx_data  = d;
    vld[sel] = 1'b1;
    tick();
    vld[sel] = 1'b0;
    check({name, " ready_after_accept"}, {31'd0, rdy[sel]}, 32'd0);
    for (int k = 0; k < len; k++) begin
      tick();
      check($sformatf("%s bit%0d", name, k), {31'd0, line[sel]}, {31'd0, exp[k]});
      check($sformatf("%s busy%0d", name, k), {31'd0, bsy[sel]}, 32'd1);
      if (k < len - 1)
        check($sformatf("%s nodone%0d", name, k), {31'd0, fd[sel]}, 32'd0);
    end
    tick();
    check({name, " frame_done"}, {31'd0, fd[sel]}, 32'd1);
    check({name, " busy_fall"}, {31'd0, bsy[sel]}, 32'd0);
    check({name, " line_idle"}, {31'd0, line[sel]}, 32'd1);
    tick();
    check({name, " done_once"}, {31'd0, fd[sel]}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [21:0] b2b;
    logic [10:0] f55;

    vecs[0] = '{8'hA5, 11'b11_1010_0101_0};
    vecs[1] = '{8'h00, 11'b11_0000_0000_0};
    vecs[2] = '{8'hFF, 11'b11_1111_1111_0};
    vecs[3] = '{8'h3C, 11'b11_0011_1100_0};
    vecs[4] = '{8'h01, 11'b11_0000_0001_0};
    vecs[5] = '{8'h80, 11'b11_1000_0000_0};

    reset   = 1'b1;
    vld     = 3'b000;
    tx_data = 8'h00;

    // Reset values
    repeat (3) @(posedge outclk);
    @(negedge outclk);
    check("rst line", {31'd0, line0}, 32'd1);
    check("rst ready", {31'd0, rdy[0]}, 32'd1);
    check("rst busy", {31'd0, bsy0}, 32'd0);
    check("rst done", {31'd0, fd0}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle line%0d", i), {31'd0, line0}, 32'd1);
    end
    check("idle busy", {31'd0, bsy0}, 32'd0);
    check("idle ready", {31'd0, rdy[0]}, 32'd1);

    // Default frames from the table
    for (int i = 0; i < 6; i++)
      run_frame(0, vecs[i].data, {1'b1, vecs[i].frame}, 11, $sformatf("vec%0d", i));

    // Parity, 12-cycle frames
    run_frame(1, 8'h07, 12'b11_1_0000_0111_0, 12, "even07");
    run_frame(2, 8'h07, 12'b11_0_0000_0111_0, 12, "odd07");
    run_frame(1, 8'h00, 12'b11_0_0000_0000_0, 12, "even00");
    run_frame(2, 8'h00, 12'b11_1_0000_0000_0, 12, "odd00");

    // Back-to-back 0x3C then 0xFF, with an ignored 0x12 offered while the holding register is full
    b2b = 22'b11_1111_1111_0_11_0011_1100_0;
    @(negedge outclk);
    tx_data = 8'h3C;
    vld[0]  = 1'b1;
    tick();
    check("b2b ready_held", {31'd0, rdy[0]}, 32'd0);
    tx_data = 8'hFF;
    for (int k = 0; k < 22; k++) begin
      tick();
      check($sformatf("b2b bit%0d", k), {31'd0, line0}, {31'd0, b2b[k]});
      check($sformatf("b2b busy%0d", k), {31'd0, bsy0}, 32'd1);
      if (k == 0) check("b2b ready_reopen", {31'd0, rdy[0]}, 32'd1);
      if (k == 1) begin
        check("b2b ready_second_held", {31'd0, rdy[0]}, 32'd0);
        vld[0] = 1'b0;
      end
      if (k == 4) begin
        tx_data = 8'h12;
        vld[0]  = 1'b1;
      end
      if (k == 5) vld[0] = 1'b0;
      if (k == 10) check("b2b ready_before_drain", {31'd0, rdy[0]}, 32'd0);
      if (k == 11) begin
        check("b2b done_first", {31'd0, fd0}, 32'd1);
        check("b2b ready_after_drain", {31'd0, rdy[0]}, 32'd1);
      end
    end
    tick();
    check("b2b done_second", {31'd0, fd0}, 32'd1);
    check("b2b busy_fall", {31'd0, bsy0}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("ignored line%0d", i), {31'd0, line0}, 32'd1);
      check($sformatf("ignored busy%0d", i), {31'd0, bsy0}, 32'd0);
    end

    // Reset during data bit 3 of 0x55, with 0xAA queued
    f55 = 11'b11_0101_0101_0;
    @(negedge outclk);
    tx_data = 8'h55;
    vld[0]  = 1'b1;
    tick();
    vld[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rstmid bit%0d", k), {31'd0, line0}, {31'd0, f55[k]});
      if (k == 0) begin
        check("rstmid ready_for_queue", {31'd0, rdy[0]}, 32'd1);
        tx_data = 8'hAA;
        vld[0]  = 1'b1;
      end
      if (k == 1) vld[0] = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid line", {31'd0, line0}, 32'd1);
    check("rstmid busy", {31'd0, bsy0}, 32'd0);
    check("rstmid done", {31'd0, fd0}, 32'd0);
    check("rstmid ready", {31'd0, rdy[0]}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("rstmid idle%0d", i), {31'd0, line0}, 32'd1);
      check($sformatf("rstmid nodone%0d", i), {31'd0, fd0}, 32'd0);
    end
    run_frame(0, 8'h0F, 12'b1_11_0000_1111_0, 11, "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_transmitir.md
# uart_transmitir

- Bit-clocked UART transmitter; the transmit end of the link whose companion receiver samples one bit per `outclk` edge.
- Accepts a parallel byte through a valid/ready handshake and buffers it in a one-deep holding register.
- Serialises the byte as a frame: start bit (0), data LSB first, optional parity, then stop bits (1).
- Each bit lasts exactly one `outclk` cycle, and frames can be sent back to back with no idle gap.

## Interface
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 2: stop-bit cycles per frame; legal values 1 or 2. The default of 2 matches the companion receiver.
- PARITY_EN, 0: 1 inserts one parity bit after the last data bit.
- PARITY_ODD, 0: selects the parity sense when PARITY_EN=1. 0 = even (XOR of the data bits); 1 = odd (inverted XOR).
- outclk, input, 1: bit-rate clock; all state changes on its rising edge.
- reset, input, 1: synchronous, active-high.
- tx_data, input, DATA_BITS: byte to send; captured on accept.
- tx_valid, input, 1: producer offers tx_data.
- tx_ready, output, 1: equals !hold_full; holding register is empty.
- SalidaTx, output, 1: serial line; registered; idles high.
- busy, output, 1: registered; 1 whenever the FSM is not IDLE.
- frame_done, output, 1: registered one-cycle pulse after the final stop bit of each frame.

## Operation
- Reset (reset=1 at an edge):
  - state=IDLE, SalidaTx=1, hold_full=0 (so tx_ready=1), busy=0, frame_done=0, bit counter=0.
  - Reset mid-frame abandons the frame: the line returns high at that edge and the held byte is discarded.
- Accept:
  - A byte is accepted at an edge where tx_valid=1 and tx_ready=1. At that edge hold_reg<=tx_data and hold_full<=1.
  - tx_valid while tx_ready=0 is ignored; the data is not captured and no error is raised.
  - Accept is legal in any state, including mid-frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: SalidaTx=1. If hold_full, at the next edge: state<=START, SalidaTx<=0, shift<=hold_reg, hold_full<=0.
  - START: lasts one cycle, then state<=DATA and SalidaTx<=shift[0].
  - DATA: lasts DATA_BITS cycles. Each edge shifts right, and the bit counter counts 0..DATA_BITS-1.
    - After the last data bit: go to PARITY (if PARITY_EN) with SalidaTx<=parity, else to STOP with SalidaTx<=1.
    - Parity is computed from the byte loaded into shift, not from hold_reg.
  - PARITY: lasts one cycle, then state<=STOP and SalidaTx<=1.
  - STOP: lasts STOP_BITS cycles. At the edge ending the last stop cycle, frame_done<=1 and then:
    - if hold_full, go directly to START (SalidaTx<=0, reload shift, clear hold_full);
    - otherwise go to IDLE.
- The holding register drain and a new accept are mutually exclusive within one edge, because tx_ready=0 whenever hold_full=1.
- frame_done is 1 for exactly one cycle and 0 in every other cycle.

## Timing
- Accept at edge E → SalidaTx falls at edge E+1, provided the FSM was IDLE.
- If a frame is in progress at E, the new start bit follows that frame's last stop bit with zero idle cycles.
- Frame length L = 1 + DATA_BITS + PARITY_EN + STOP_BITS cycles. Default L = 11.
- Line timing with the default parameters:
  - start bit occupies cycle E+1..E+2;
  - data bit i occupies E+2+i..E+3+i;
  - stop bits occupy E+10..E+12.
- Status outputs with the default parameters:
  - busy rises at E+1 and falls at E+12, unless a back-to-back frame follows;
  - frame_done is high during E+12..E+13.
- tx_ready:
  - returns to 1 at the edge that starts the frame (E+1 when idle), so a second byte can be queued during the first frame;
  - combinational from a register only; it has no dependence on tx_valid.
- Sustained throughput: one frame every L cycles when tx_valid is held high.

## Test plan
- **Reset values.** Hold reset for 3 cycles, then release → SalidaTx=1, tx_ready=1, busy=0, frame_done=0. The line stays high for 20 idle cycles.
- **Single default frame.** Send 0xA5 at edge E → SalidaTx from E+1 reads 0,1,0,1,0,0,1,0,1,1,1, then stays at 1. frame_done pulses once, at E+12. busy is high E+1..E+12.
- **Back-to-back frames.** Hold tx_valid=1 with 0x3C then 0xFF → second start bit immediately follows the first frame's second stop bit. Observed sequence: 0,0,0,1,1,1,1,0,0,1,1 then 0,1,1,1,1,1,1,1,1,1,1. tx_ready is 0 only while a byte is held.
- **Parity.** With PARITY_EN=1, PARITY_ODD=0, send 0x07 → the bit after data is 1 and the frame is 12 cycles. With PARITY_ODD=1 the same byte gives parity 0. With 0x00, even parity gives 0.
- **Reset mid-frame.** Send 0x55, assert reset during data bit 3 → SalidaTx=1 at the next edge, busy=0, no frame_done. A queued 0xAA held before the reset is discarded, and the next accepted byte transmits cleanly.
- **Ignored valid.** Pulse tx_valid with 0x12 while tx_ready=0 → the byte is never transmitted, and the frame in progress is unchanged.
